// File: rtl/wb_regfile_scoreboard_if.sv
// wb_regfile_scoreboard_if: write-back and decode-read bundle for the register file / scoreboard
// master: pipeline side (drives write-back, read indices, issue info; receives read data, stall, error)
// slave:  register file side
interface wb_regfile_scoreboard_if #(
    parameter int DATA_W = 32
);
    logic              W_regWrite_W;
    logic [4:0]        W_writeReg_W;
    logic [DATA_W-1:0] W_Result_W;
    logic [4:0]        D_rs_D;
    logic [4:0]        D_rt_D;
    logic [DATA_W-1:0] D_rd1_D;
    logic [DATA_W-1:0] D_rd2_D;
    logic              D_issue_D;
    logic [4:0]        D_issueReg_D;
    logic              D_useRs_D;
    logic              D_useRt_D;
    logic              D_stall_D;
    logic              sb_err;
    modport master (
        output W_regWrite_W, W_writeReg_W, W_Result_W, D_rs_D, D_rt_D,
               D_issue_D, D_issueReg_D, D_useRs_D, D_useRt_D,
        input  D_rd1_D, D_rd2_D, D_stall_D, sb_err
    );
    modport slave (
        input  W_regWrite_W, W_writeReg_W, W_Result_W, D_rs_D, D_rt_D,
               D_issue_D, D_issueReg_D, D_useRs_D, D_useRt_D,
        output D_rd1_D, D_rd2_D, D_stall_D, sb_err
    );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: 32x32 register file with write-first bypass and per-register pending-write scoreboard
// Ports: clk, rst_n (async active-low), bus (slave modport: write-back, two read ports, issue/stall, sticky sb_err)
module wb_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    wb_regfile_scoreboard_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [DATA_W-1:0] regs    [1:31];
    logic [CNT_W-1:0]  cnt     [1:31];
    logic [CNT_W-1:0]  cnt_nxt [1:31];
    logic [31:1]       inc;
    logic [31:1]       dec;
    logic [31:0]       pend;
    logic              err_now;
    logic              sb_err_q;
    logic              wr_en;
    assign wr_en = bus.W_regWrite_W && bus.W_writeReg_W != 5'd0;
    // while in reset the array is already cleared; gating on rst_n also suppresses the bypass
    assign bus.D_rd1_D = (!rst_n || bus.D_rs_D == 5'd0) ? '0 :
                         (wr_en && bus.W_writeReg_W == bus.D_rs_D) ? bus.W_Result_W : regs[bus.D_rs_D];
    assign bus.D_rd2_D = (!rst_n || bus.D_rt_D == 5'd0) ? '0 :
                         (wr_en && bus.W_writeReg_W == bus.D_rt_D) ? bus.W_Result_W : regs[bus.D_rt_D];
    assign bus.D_stall_D = rst_n && ((bus.D_useRs_D && pend[bus.D_rs_D]) ||
                                     (bus.D_useRt_D && pend[bus.D_rt_D]));
    assign bus.sb_err = sb_err_q;
    always_comb begin
        pend    = '0;
        inc     = '0;
        dec     = '0;
        err_now = 1'b0;
        for (int i = 1; i < 32; i++) begin
            inc[i]     = bus.D_issue_D && bus.D_issueReg_D == 5'(i);
            dec[i]     = bus.W_regWrite_W && bus.W_writeReg_W == 5'(i);
            cnt_nxt[i] = cnt[i];
            if (inc[i] && !dec[i]) begin
                if (cnt[i] == CNT_MAX) err_now = 1'b1;
                else cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
            if (dec[i] && !inc[i]) begin
                if (cnt[i] == '0) err_now = 1'b1;
                else cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
            // a sole remaining writer landing this cycle is covered by the read bypass
            pend[i] = cnt[i] != '0 && !(cnt[i] == CNT_W'(1) && dec[i]);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (wr_en) regs[bus.W_writeReg_W] <= bus.W_Result_W;
            for (int i = 1; i < 32; i++) cnt[i] <= cnt_nxt[i];
            sb_err_q <= sb_err_q | err_now;
        end
    end
endmodule
